// File: rtl/sin_sweep_ctrl_pkg.sv
// sin_ctrl_pkg: shared widths and FSM state encoding for the sine sweep sequencer
package sin_ctrl_pkg;

    localparam int PHASE_W = 16;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 16;
    localparam int DIV_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sin_sweep_ctrl_if.sv
// sin_sweep_ctrl_if: control, table and sample-stream signals of the sweep sequencer
interface sin_sweep_ctrl_if;
    import sin_ctrl_pkg::*;

    logic               start;
    logic               stop;
    logic [PHASE_W-1:0] phase_init;
    logic [PHASE_W-1:0] tune;
    logic [DIV_W-1:0]   div;
    logic [CNT_W-1:0]   count;
    logic               tbl_rd;
    logic [ADDR_W-1:0]  tbl_addr;
    logic [DATA_W-1:0]  tbl_data;
    logic [DATA_W-1:0]  sample;
    logic               sample_valid;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, phase_init, tune, div, count, tbl_data,
        input  tbl_rd, tbl_addr, sample, sample_valid, busy, done
    );

    modport slave (
        input  start, stop, phase_init, tune, div, count, tbl_data,
        output tbl_rd, tbl_addr, sample, sample_valid, busy, done
    );

endinterface

// File: rtl/sin_sweep_ctrl_phase_accum.sv
// phase_accum: phase accumulator that can load a start phase and advance by tune in the same cycle
module phase_accum
    import sin_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PHASE_W-1:0] init,
    input  logic               step,
    input  logic [PHASE_W-1:0] tune,
    output logic [PHASE_W-1:0] phase
);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] base;

    assign base  = load ? init : phase_q;
    assign phase = phase_q;

    // Load replaces the accumulator, step adds tune with silent modulo wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            phase_q <= '0;
        else if (load || step)
            phase_q <= base + (step ? tune : '0);
    end

endmodule

// File: rtl/sin_sweep_ctrl.sv
// sin_sweep_ctrl: DDS sequencer issuing sine-table reads and registering the returned samples
module sin_sweep_ctrl
    import sin_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    sin_sweep_ctrl_if.slave bus
);

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] tune_q;
    logic [PHASE_W-1:0] tune_sel;
    logic [PHASE_W-1:0] phase;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_cnt_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   issued_q;
    logic [ADDR_W-1:0]  tbl_addr_q;
    logic [DATA_W-1:0]  sample_q;
    logic               tbl_rd_q;
    logic               rd_d1_q;
    logic               sample_valid_q;
    logic               busy_q;
    logic               done_q;
    logic               accept;
    logic               finish;
    logic               issue;
    logic               unused_phase_lsb;

    // Reads are decided one edge early so tbl_rd is registered; the start edge issues the first read
    assign accept   = (state_q == IDLE) && bus.start;
    assign finish   = (state_q == RUN) && (bus.stop || (count_q != '0 && issued_q == count_q));
    assign issue    = accept || ((state_q == RUN) && !finish && div_cnt_q == '0);
    assign tune_sel = accept ? bus.tune : tune_q;

    assign unused_phase_lsb = ^phase[PHASE_W-ADDR_W-1:0];

    phase_accum u_phase (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .init  (bus.phase_init),
        .step  (issue),
        .tune  (tune_sel),
        .phase (phase)
    );

    // Next state: start only from IDLE, stop or final read ends RUN, DRAIN is a single cycle
    always_comb
        state_d = accept ? RUN : finish ? DRAIN : (state_q == DRAIN) ? IDLE : state_q;

    // FSM state, sweep parameters, divider, issued-counter and registered table strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tune_q     <= '0;
            div_q      <= '0;
            count_q    <= '0;
            div_cnt_q  <= '0;
            issued_q   <= '0;
            tbl_rd_q   <= 1'b0;
            tbl_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= state_d != IDLE;
            done_q    <= state_q == DRAIN;
            tbl_rd_q  <= issue;
            issued_q  <= accept ? CNT_W'(1) : issue ? issued_q + CNT_W'(1) : issued_q;
            div_cnt_q <= accept ? bus.div
                       : issue ? div_q
                       : (state_q == RUN && div_cnt_q != '0) ? div_cnt_q - DIV_W'(1)
                       : div_cnt_q;
            if (accept) begin
                tune_q  <= bus.tune;
                div_q   <= bus.div;
                count_q <= bus.count;
            end
            if (issue)
                tbl_addr_q <= accept ? bus.phase_init[PHASE_W-1 -: ADDR_W] : phase[PHASE_W-1 -: ADDR_W];
        end
    end

    // Sample path: table data is valid the cycle after tbl_rd and is captured one edge later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_d1_q        <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_q       <= '0;
        end else begin
            rd_d1_q        <= tbl_rd_q;
            sample_valid_q <= rd_d1_q;
            if (rd_d1_q)
                sample_q <= bus.tbl_data;
        end
    end

    assign bus.tbl_rd       = tbl_rd_q;
    assign bus.tbl_addr     = tbl_addr_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_sin_sweep_ctrl.sv
// tb_sin_sweep_ctrl: directed sweeps checked every cycle against a per-cycle expectation timeline
module tb_sin_sweep_ctrl;

    localparam int N = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   rd_seen = 0;

    bit       e_rd   [N];
    bit       e_sv   [N];
    bit       e_busy [N];
    bit       e_done [N];
    bit [7:0] e_addr [N];
    bit [7:0] e_smp  [N];

    sin_sweep_ctrl_if bus ();

    sin_sweep_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit [7:0] tbl_f(input bit [7:0] a);
        return 8'(a * 7 + 3);
    endfunction

    // Registered lookup table: data appears the cycle after the read strobe
    always @(posedge clk)
        if (bus.tbl_rd) bus.tbl_data <= tbl_f(bus.tbl_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Every cycle: DUT outputs against the expected timeline
    always @(negedge clk) begin
        if (cyc < N) begin
            if (bus.tbl_rd) rd_seen++;
            chk("tbl_rd", bus.tbl_rd, e_rd[cyc]);
            if (e_rd[cyc]) chk("tbl_addr", bus.tbl_addr, e_addr[cyc]);
            chk("sample_valid", bus.sample_valid, e_sv[cyc]);
            if (e_sv[cyc]) chk("sample", bus.sample, e_smp[cyc]);
            chk("busy", bus.busy, e_busy[cyc]);
            chk("done", bus.done, e_done[cyc]);
        end
    end

    task automatic clr(input int from);
        for (int i = from; i < N; i++) begin
            e_rd[i] = 0; e_sv[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_addr[i] = 0; e_smp[i] = 0;
        end
    endtask

    // Timeline of a sweep whose RUN cycle 1 is absolute cycle base; s = RUN cycle in which stop is held
    task automatic plan(input int base, input bit [15:0] pi, input bit [15:0] tn, input bit [7:0] dv,
                        input bit [15:0] cn, input int s, output int done_c);
        bit [15:0] ph;
        int r, lr, fin;
        clr(base);
        ph = pi;
        lr = 0;
        for (int k = 0; k < 4000; k++) begin
            r = 1 + k * (int'(dv) + 1);
            if ((cn != 0 && k >= int'(cn)) || (s != 0 && r > s) || base + r + 1 >= N) break;
            e_rd[base + r - 1]   = 1;
            e_addr[base + r - 1] = ph[15:8];
            e_sv[base + r + 1]   = 1;
            e_smp[base + r + 1]  = tbl_f(ph[15:8]);
            ph = ph + tn;
            lr = r;
        end
        fin = (cn != 0) ? lr : s;
        if (s != 0 && s < fin) fin = s;
        for (int i = 1; i <= fin + 1; i++) e_busy[base + i - 1] = 1;
        done_c = base + fin + 1;
        e_done[done_c] = 1;
    endtask

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic at_cycle(input int a);
        while (cyc < a) next();
    endtask

    task automatic go(input int a);
        at_cycle(a);
        @(negedge clk);
        #1;
    endtask

    task automatic sweep(input bit [15:0] pi, input bit [15:0] tn, input bit [7:0] dv, input bit [15:0] cn,
                         input int s, input bit hold, output int base, output int done_c);
        bus.phase_init = pi;
        bus.tune       = tn;
        bus.div        = dv;
        bus.count      = cn;
        bus.start      = 1'b1;
        base = cyc + 1;
        plan(base, pi, tn, dv, cn, s, done_c);
        next();
        if (!hold) bus.start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, d, b2, d2;
        bus.start = 0; bus.stop = 0; bus.phase_init = 0; bus.tune = 0; bus.div = 0; bus.count = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk); #1;
        chk("reset tbl_rd", bus.tbl_rd, 0);
        chk("reset tbl_addr", bus.tbl_addr, 0);
        chk("reset sample", bus.sample, 0);
        chk("reset sample_valid", bus.sample_valid, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);

        sweep(16'h0000, 16'h0100, 8'd0, 16'd4, 0, 0, b, d);
        go(b + 2); chk("basic first sample", {bus.sample_valid, bus.sample}, {1'b1, 8'h03});
        go(b + 3); chk("basic 4th addr", {bus.tbl_rd, bus.tbl_addr}, {1'b1, 8'h03});
        go(b + 5); chk("basic done/busy/last", {bus.done, bus.busy, bus.sample_valid, bus.sample}, {3'b101, 8'h18});

        sweep(16'h0000, 16'h0100, 8'd2, 16'd3, 0, 0, b, d);
        go(b + 6); chk("div 3rd read at RUN 7", bus.tbl_rd, 1);
        go(b + 8); chk("div last sample with done", {bus.done, bus.sample_valid, bus.sample}, {2'b11, 8'h11});

        sweep(16'hFF00, 16'h0080, 8'd0, 16'd4, 0, 0, b, d);
        go(b + 1); chk("wrap 2nd addr", bus.tbl_addr, 8'hFF);
        go(b + 2); chk("wrap 3rd addr", bus.tbl_addr, 8'h00);
        go(d);

        rd_seen = 0;
        sweep(16'h1000, 16'h0100, 8'd0, 16'd0, 10, 0, b, d);
        at_cycle(b + 9);
        bus.stop = 1'b1;
        next();
        bus.stop = 1'b0;
        go(d); chk("stop last sample with done", {bus.done, bus.sample_valid, bus.sample}, {2'b11, 8'hB2});
        go(d + 2); chk("stop read count", rd_seen, 10);

        sweep(16'h1234, 16'h0200, 8'd1, 16'd3, 0, 1, b, d);
        bus.tune = 16'hFFFF;
        bus.phase_init = 16'hDEAD;
        go(b + 2); chk("held start 2nd addr", bus.tbl_addr, 8'h14);
        go(b + 4); chk("held start 3rd addr", bus.tbl_addr, 8'h16);
        at_cycle(d);
        sweep(16'h4000, 16'h0300, 8'd0, 16'd2, 0, 0, b2, d2);
        go(b2); chk("restart on done 1st addr", bus.tbl_addr, 8'h40);
        go(b2 + 1); chk("restart new tune 2nd addr", bus.tbl_addr, 8'h43);
        go(d2);

        sweep(16'h0500, 16'h0100, 8'd0, 16'd20, 0, 0, b, d);
        at_cycle(b + 2);
        rst = 1'b1;
        clr(b + 2);
        @(negedge clk); #1;
        chk("mid reset outputs", {bus.tbl_rd, bus.tbl_addr, bus.sample_valid, bus.sample, bus.busy, bus.done}, 0);
        next();
        rst = 1'b0;
        next();
        sweep(16'h0500, 16'h0100, 8'd0, 16'd2, 0, 0, b, d);
        go(b); chk("post reset restart addr", bus.tbl_addr, 8'h05);
        go(d); chk("post reset done", bus.done, 1);
        go(d + 2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sin_sweep_ctrl.md
# sin_sweep_ctrl

Sequencer that drives the 256-entry sine lookup table as a direct digital synthesis (DDS) source. It owns a phase accumulator, a sample-rate divider and a sample counter, and issues `rd`/`addr` to the table. It registers the returned table data as a one-cycle-valid sample stream. It sits between the control register block (start, tune, count) and the table; downstream consumers see only `sample`/`sample_valid`.

## Interface
- `PHASE_W`, 16, phase accumulator width; table address is its top `ADDR_W` bits
- `ADDR_W`, 8, table address width
- `DATA_W`, 8, table data width
- `CNT_W`, 16, sample count width

- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: begin a sweep; sampled only in IDLE
- `stop` in 1: abort a sweep; sampled only in RUN
- `phase_init` in PHASE_W: starting phase, latched on start
- `tune` in PHASE_W: phase increment per sample, latched on start
- `div` in 8: idle cycles between reads, latched on start
- `count` in CNT_W: samples to produce; 0 = continuous until stop
- `tbl_rd` out 1: table read strobe, registered
- `tbl_addr` out ADDR_W: table address, registered, holds between reads
- `tbl_data` in DATA_W: table `d_out`, valid the cycle after `tbl_rd`
- `sample` out DATA_W: registered table value
- `sample_valid` out 1: one-cycle strobe per sample
- `busy` out 1: high in RUN and DRAIN
- `done` out 1: one-cycle pulse on return to IDLE

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE + `start`:
  - latch `phase_init`, `tune`, `div`, `count`
  - clear the issued-counter and the divider
  - next state RUN
- RUN:
  - When the divider is 0, issue a read:
    - `tbl_rd`=1 for one cycle
    - `tbl_addr` = `phase[PHASE_W-1 -: ADDR_W]`
    - `phase` += `tune`, modulo 2^PHASE_W, silent wrap
    - issued-counter +1
    - divider reloads `div`
  - Otherwise the divider decrements and `tbl_rd`=0.
  - The first read is issued on the first RUN cycle.
- RUN exits to DRAIN when either:
  - `count`≠0 and the issued-counter reaches `count` (edge after the last read), or
  - `stop`=1; no read is issued after the edge that samples `stop`.
  - When the issued-counter reaches `count` and `stop` is sampled at the same edge, the result is identical.
- DRAIN lasts one cycle, lets the in-flight read complete, then goes to IDLE. On that transition, `done` is registered to 1.
- Sample path: `rd_d1` <= `tbl_rd`. When `rd_d1`=1, `sample` <= `tbl_data` and `sample_valid` <= 1; otherwise `sample_valid` <= 0 and `sample` holds.
- `start` in RUN/DRAIN is ignored. `stop` in IDLE/DRAIN is ignored.
- `count`=0 runs indefinitely; the issued-counter wraps and is not compared.

## Timing
- Reset values:
  - `tbl_rd`=0, `tbl_addr`=0
  - `sample`=0, `sample_valid`=0
  - `busy`=0, `done`=0
  - phase=0, counters=0
  - state IDLE
- `rst` mid-sweep aborts immediately. No `done`, no further `sample_valid`.
- `start` sampled at edge E: `tbl_rd`=1 during the cycle after E (RUN cycle 1), and `busy`=1 from that cycle.
- Read latency: `tbl_rd` in cycle t gives `sample_valid` in cycle t+2.
- Read spacing: `div`+1 cycles. `div`=0 gives one read per cycle.
- Last read in cycle t:
  - DRAIN in cycle t+1
  - cycle t+2: IDLE, `busy`=0, `done`=1, `sample_valid`=1 (last sample)
- Stop sampled at edge ending cycle s: DRAIN in s+1, IDLE with `done`=1 in s+2. `sample_valid` in s+2 only if a read was issued in cycle s.
- A new `start` is accepted the same cycle `done` is high (state is IDLE).

## Structure
- Package `sin_ctrl_pkg` holds:
  - state enum (IDLE, RUN, DRAIN)
  - default widths: PHASE_W, ADDR_W, DATA_W, CNT_W
- Sub-module `phase_accum`: load/step accumulator. Ports: `clk`, `rst`, `load`, `init`, `step`, `tune`, `phase`.
- The FSM, divider, issued-counter and sample register live in `sin_sweep_ctrl`. The table is instantiated by the parent, not inside this block.

## Test plan
- Basic sweep: `phase_init`=0x0000, `tune`=0x0100, `div`=0, `count`=4 -> `tbl_addr` 00,01,02,03 on 4 consecutive cycles; 4 `sample_valid` equal to table[0..3], first 2 cycles after the first `tbl_rd`; `done` with the 4th sample; `busy` falls the same cycle.
- Divider: `div`=2, `count`=3 -> `tbl_rd` in cycles 1, 4, 7 of RUN; samples in cycles 3, 6, 9.
- Wrap and fraction: `phase_init`=0xFF00, `tune`=0x0080, `count`=4 -> addresses FF, FF, 00, 00.
- Stop: `count`=0, `div`=0, `stop` pulsed at RUN cycle 10 -> exactly 10 reads; last `sample_valid` coincides with `done`; no `tbl_rd` after.
- Protocol: `start` held high during RUN -> ignored; `start` on the `done` cycle -> new sweep begins next cycle with freshly latched `tune`.
- Reset mid-sweep: `rst` asserted in RUN cycle 3 -> all outputs 0 asynchronously, no `done`; a fresh sweep after release restarts from `phase_init`.
